// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall codes, FSM states, reset level.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Stall vector codes: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved.
    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;

    // This block resets on a low level.
    localparam logic        RstEnable  = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_DIV_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones.
// Latency: count updates on the clock after i_inc is seen.
// Backpressure: none; increments past all-ones are dropped.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count enabled cycles, stopping once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall vector, exception flush/redirect, divider start/annul with watchdog.
// Latency: stall/flush/new_pc/div_start/div_annul are combinational; state, error flag and counter are registered.
// Backpressure: the pipeline is frozen via stall while the divider is pending; the watchdog bounds that freeze.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stallreq,
    input  logic             ex_div_req,
    input  logic             div_ready,
    input  logic             excp_valid,
    input  logic [31:0]      excp_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             div_start,
    output logic             div_annul,
    output logic             div_busy,
    output logic             div_timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WCNT_W    = $clog2(DIV_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DIV_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_nxt;
    logic              r_timeout_err;
    logic              w_err_set;
    logic              w_in_rst;

    assign w_in_rst = (rst == RstEnable);

    // State, wait counter and sticky watchdog flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_timeout_err <= r_timeout_err | w_err_set;
        end
    end

    // Next state and outputs; priority is exception, then divider, then load-use.
    always_comb begin
        stall       = STALL_NONE;
        flush       = 1'b0;
        new_pc      = ZeroWord;
        div_start   = 1'b0;
        div_annul   = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_set   = 1'b0;

        if (excp_valid) begin
            // Redirect; any divide in flight or about to start is dropped.
            flush       = 1'b1;
            new_pc      = excp_pc;
            div_annul   = (r_state == ST_DIV_WAIT) || ex_div_req;
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (ex_div_req) begin
                        // The divider freeze already covers any load-use stall.
                        div_start   = 1'b1;
                        stall       = STALL_EX;
                        w_state_nxt = ST_DIV_WAIT;
                        w_wait_nxt  = '0;
                    end else if (id_stallreq) begin
                        stall = STALL_ID;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_ready) begin
                        // Release so EX/MEM captures the quotient; ex_div_req still high is the same op.
                        w_state_nxt = ST_RUN;
                        w_wait_nxt  = '0;
                    end else if (r_wait_cnt != WCNT_LAST) begin
                        stall      = STALL_EX;
                        w_wait_nxt = r_wait_cnt + WCNT_W'(1);
                    end else begin
                        div_annul   = 1'b1;
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_RUN;
                        w_wait_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            endcase
        end

        // Everything combinational is quiet while reset is held.
        if (w_in_rst) begin
            stall     = STALL_NONE;
            flush     = 1'b0;
            new_pc    = ZeroWord;
            div_start = 1'b0;
            div_annul = 1'b0;
        end
    end

    assign div_busy        = !w_in_rst && (r_state == ST_DIV_WAIT);
    assign div_timeout_err = r_timeout_err;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_inc (stall[0]),
        .o_cnt (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
// Latency: outputs sampled 1 time unit after inputs change, midway between rising edges.
// Backpressure: n/a.
module tb_pipe_ctrl;

    localparam int TO = 8;

    localparam logic [9:0] V_NONE    = 10'b000000_0000;
    localparam logic [9:0] V_ID      = 10'b000111_0000;
    localparam logic [9:0] V_START   = 10'b001111_0100;
    localparam logic [9:0] V_WAIT    = 10'b001111_0001;
    localparam logic [9:0] V_READY   = 10'b000000_0001;
    localparam logic [9:0] V_TOUT    = 10'b000000_0011;
    localparam logic [9:0] V_EXC_DIV = 10'b000000_1011;
    localparam logic [9:0] V_EXC_RUN = 10'b000000_1010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_stallreq = 1'b0;
    logic        ex_div_req = 1'b0;
    logic        div_ready = 1'b0;
    logic        excp_valid = 1'b0;
    logic [31:0] excp_pc = 32'h0;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_start, div_annul, div_busy, div_timeout_err;
    logic [31:0] stall_cycles;

    logic [5:0]  s_stall;
    logic        s_flush;
    logic [31:0] s_new_pc;
    logic        s_start, s_annul, s_busy, s_err;
    logic [2:0]  s_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_div_req(ex_div_req),
        .div_ready(div_ready), .excp_valid(excp_valid), .excp_pc(excp_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .div_start(div_start),
        .div_annul(div_annul), .div_busy(div_busy), .div_timeout_err(div_timeout_err),
        .stall_cycles(stall_cycles)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    pipe_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_div_req(ex_div_req),
        .div_ready(div_ready), .excp_valid(excp_valid), .excp_pc(excp_pc),
        .stall(s_stall), .flush(s_flush), .new_pc(s_new_pc), .div_start(s_start),
        .div_annul(s_annul), .div_busy(s_busy), .div_timeout_err(s_err),
        .stall_cycles(s_cycles)
    );

    // Reference model: "waiting on divider" flag, number of wait cycles already spent, error, stall count.
    bit          m_in_div;
    int          m_waits;
    bit          m_err;
    logic [63:0] m_cnt;
    int          m_cnt_s;

    logic [5:0]  e_stall;
    logic        e_flush, e_start, e_annul, e_busy;
    logic [31:0] e_new_pc;

    // Expected combinational outputs for the current model state and inputs.
    always_comb begin
        e_stall = 6'b0; e_flush = 1'b0; e_new_pc = 32'h0;
        e_start = 1'b0; e_annul = 1'b0; e_busy = 1'b0;
        if (rst) begin
            e_busy = m_in_div;
            if (excp_valid) begin
                e_flush  = 1'b1;
                e_new_pc = excp_pc;
                e_annul  = m_in_div || ex_div_req;
            end else if (!m_in_div) begin
                if (ex_div_req)       begin e_start = 1'b1; e_stall = 6'b001111; end
                else if (id_stallreq) e_stall = 6'b000111;
            end else if (!div_ready) begin
                // This is wait cycle number m_waits+1; the TO-th one is the watchdog cycle.
                if (m_waits + 1 < TO) e_stall = 6'b001111;
                else                  e_annul = 1'b1;
            end
        end
    end

    // Advance the model on each rising edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in_div <= 1'b0; m_waits <= 0; m_err <= 1'b0; m_cnt <= 64'd0; m_cnt_s <= 0;
        end else begin
            if (e_stall[0]) begin
                if (m_cnt != 64'h0000_0000_FFFF_FFFF) m_cnt <= m_cnt + 64'd1;
                if (m_cnt_s < 7) m_cnt_s <= m_cnt_s + 1;
            end
            if (excp_valid)              m_in_div <= 1'b0;
            else if (!m_in_div) begin
                if (ex_div_req) begin m_in_div <= 1'b1; m_waits <= 0; end
            end
            else if (div_ready)          m_in_div <= 1'b0;
            else if (m_waits + 1 < TO)   m_waits <= m_waits + 1;
            else begin m_in_div <= 1'b0; m_err <= 1'b1; end
        end
    end

    function automatic logic [9:0] obs();
        return {stall, flush, div_start, div_annul, div_busy};
    endfunction

    function automatic logic [9:0] expv();
        return {e_stall, e_flush, e_start, e_annul, e_busy};
    endfunction

    task automatic drive(input logic id, input logic dv, input logic rdy, input logic ex, input logic [31:0] pc);
        id_stallreq = id; ex_div_req = dv; div_ready = rdy; excp_valid = ex; excp_pc = pc;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        id_stallreq = 0; ex_div_req = 0; div_ready = 0; excp_valid = 0; excp_pc = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 32'hDEAD_BEEF);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL rst_outs: got %b expected %b", obs(), V_NONE); end
        n_checks++; if (new_pc !== 32'h0) begin n_errors++; $display("FAIL rst_new_pc: got %h expected 0", new_pc); end
        n_checks++; if (stall_cycles !== 32'd0 || div_timeout_err !== 1'b0) begin
            n_errors++; $display("FAIL rst_regs: got cnt=%0d err=%b expected 0/0", stall_cycles, div_timeout_err); end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL lu_idle: got %b expected %b", obs(), V_NONE); end
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++; if (obs() !== V_ID) begin n_errors++; $display("FAIL lu_stall%0d: got %b expected %b", i, obs(), V_ID); end
            step();
        end
        drive(0, 0, 0, 0, 0);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL lu_release: got %b expected %b", obs(), V_NONE); end
        n_checks++; if (stall_cycles !== 32'd2) begin n_errors++; $display("FAIL lu_count: got %0d expected 2", stall_cycles); end
        step();
    endtask

    // Issue a divide and spend n plain wait cycles, checking each one.
    task automatic start_div(input int n, input string tag);
        drive(0, 1, 0, 0, 0);
        n_checks++; if (obs() !== V_START) begin n_errors++; $display("FAIL %s_start: got %b expected %b", tag, obs(), V_START); end
        step();
        for (int k = 1; k <= n; k++) begin
            drive(0, 1, 0, 0, 0);
            n_checks++; if (obs() !== V_WAIT) begin n_errors++; $display("FAIL %s_wait%0d: got %b expected %b", tag, k, obs(), V_WAIT); end
            step();
        end
    endtask

    task automatic test_divide();
        do_reset();
        start_div(5, "div");
        drive(0, 1, 1, 0, 0);
        n_checks++; if (obs() !== V_READY) begin n_errors++; $display("FAIL div_ready: got %b expected %b", obs(), V_READY); end
        step();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL div_after: got %b expected %b", obs(), V_NONE); end
        n_checks++; if (stall_cycles !== 32'd6) begin n_errors++; $display("FAIL div_count: got %0d expected 6", stall_cycles); end
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        start_div(TO - 1, "to");
        drive(0, 1, 0, 0, 0);
        n_checks++; if (obs() !== V_TOUT) begin n_errors++; $display("FAIL to_annul: got %b expected %b", obs(), V_TOUT); end
        n_checks++; if (div_timeout_err !== 1'b0) begin n_errors++; $display("FAIL to_err_early: got %b expected 0", div_timeout_err); end
        step();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL to_after: got %b expected %b", obs(), V_NONE); end
        n_checks++; if (stall_cycles !== 32'd8) begin n_errors++; $display("FAIL to_count: got %0d expected 8", stall_cycles); end
        // A later normal divide must not clear the sticky flag.
        step();
        start_div(2, "to2");
        drive(0, 1, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (div_timeout_err !== 1'b1) begin n_errors++; $display("FAIL to_sticky: got %b expected 1", div_timeout_err); end
        step();
    endtask

    task automatic test_ready_at_timeout();
        do_reset();
        start_div(TO - 1, "rt");
        drive(0, 1, 1, 0, 0);
        n_checks++; if (obs() !== V_READY) begin n_errors++; $display("FAIL rt_ready: got %b expected %b", obs(), V_READY); end
        step();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (div_timeout_err !== 1'b0) begin n_errors++; $display("FAIL rt_err: got %b expected 0", div_timeout_err); end
        step();
    endtask

    task automatic test_excp_during_div();
        do_reset();
        start_div(2, "ex");
        drive(0, 1, 0, 1, 32'h0000_0020);
        n_checks++; if (obs() !== V_EXC_DIV) begin n_errors++; $display("FAIL ex_flush: got %b expected %b", obs(), V_EXC_DIV); end
        n_checks++; if (new_pc !== 32'h0000_0020) begin n_errors++; $display("FAIL ex_new_pc: got %h expected 00000020", new_pc); end
        step();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL ex_after: got %b expected %b", obs(), V_NONE); end
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1, 1, 0, 1, 32'h0000_0100);
        n_checks++; if (obs() !== V_EXC_RUN) begin n_errors++; $display("FAIL sim_prio: got %b expected %b", obs(), V_EXC_RUN); end
        n_checks++; if (new_pc !== 32'h0000_0100) begin n_errors++; $display("FAIL sim_new_pc: got %h expected 00000100", new_pc); end
        step();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL sim_after: got %b expected %b", obs(), V_NONE); end
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++; if (s_cycles !== 3'((k < 7) ? k : 7)) begin
                n_errors++; $display("FAIL sat_narrow%0d: got %0d expected %0d", k, s_cycles, (k < 7) ? k : 7); end
            step();
        end
        drive(0, 0, 0, 0, 0);
        n_checks++; if (stall_cycles !== 32'd10) begin n_errors++; $display("FAIL sat_wide: got %0d expected 10", stall_cycles); end
        n_checks++; if (s_cycles !== 3'd7) begin n_errors++; $display("FAIL sat_hold: got %0d expected 7", s_cycles); end
        step();
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        start_div(5, "rm");
        drive(0, 1, 0, 1, 32'h0000_0040);
        rst = 1'b0;
        #1;
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL rm_outs: got %b expected %b", obs(), V_NONE); end
        n_checks++; if (stall_cycles !== 32'd0) begin n_errors++; $display("FAIL rm_count: got %0d expected 0", stall_cycles); end
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        n_checks++; if (obs() !== V_NONE) begin n_errors++; $display("FAIL rm_run: got %b expected %b", obs(), V_NONE); end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 25) == 0, $urandom);
            n_checks++; if (obs() !== expv() || new_pc !== e_new_pc) begin
                n_errors++; $display("FAIL rnd_outs%0d: got %b/%h expected %b/%h", i, obs(), new_pc, expv(), e_new_pc); end
            n_checks++; if (stall_cycles !== m_cnt[31:0] || div_timeout_err !== m_err || s_cycles !== 3'(m_cnt_s)) begin
                n_errors++; $display("FAIL rnd_regs%0d: got %0d/%b/%0d expected %0d/%b/%0d", i,
                    stall_cycles, div_timeout_err, s_cycles, m_cnt[31:0], m_err, m_cnt_s); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_timeout();
        test_ready_at_timeout();
        test_excp_during_div();
        test_simultaneous();
        test_saturate();
        test_reset_mid_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage CPU. It generates the per-stage stall vector that freezes the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and the flush/redirect used on exceptions. It sequences the multi-cycle divider through a start/ready handshake with a timeout watchdog, and keeps a stall-cycle performance counter.

Parameters:
DIV_TIMEOUT, 64, max DIV_WAIT cycles before the divider op is annulled (>=2)
CNT_W, 32, width of stall_cycles perf counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
id_stallreq  in  1  load-use hazard request from ID, combinational, level
ex_div_req  in  1  EX holds DIV/DIVU, level
div_ready  in  1  divider result valid, 1-cycle pulse
excp_valid  in  1  exception committed in MEM, level for 1 cycle
excp_pc  in  32  exception handler address
stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0)
flush  out  1  clear all pipeline registers to NOP
new_pc  out  32  redirect target, valid when flush=1
div_start  out  1  start divider, 1-cycle pulse
div_annul  out  1  abort divider, 1-cycle pulse
div_busy  out  1  state == DIV_WAIT
div_timeout_err  out  1  sticky, set on watchdog expiry
stall_cycles  out  CNT_W  cycles with stall[0]=1, saturating

Behaviour:
- State register {RUN, DIV_WAIT} plus a wait counter of width clog2(DIV_TIMEOUT)+1. stall, flush, new_pc, div_start and div_annul are combinational from state and inputs. Counters and flags are registered.
- Reset (rst=0, async): state=RUN, wait counter=0, div_timeout_err=0, stall_cycles=0. While in reset all combinational outputs are forced to 0: stall=000000, flush=0, new_pc=0, div_start=0, div_annul=0, div_busy=0.
- Priority per cycle: excp_valid > divider sequencing > id_stallreq.
- excp_valid=1, any state:
  - flush=1, new_pc=excp_pc, stall=000000.
  - If in DIV_WAIT, or in RUN with ex_div_req=1: div_annul=1 and div_start=0.
  - Next state=RUN, wait counter cleared.
- RUN, ex_div_req=1, no exception:
  - div_start=1 and stall=001111 this cycle; the ID stall is subsumed.
  - Next state=DIV_WAIT, wait counter=0.
- RUN, id_stallreq=1 only: stall=000111, so the ID/EX input becomes a bubble. State is unchanged.
- RUN, no requests: stall=000000, flush=0, new_pc=0.
- DIV_WAIT, div_ready=1:
  - stall=000000 this cycle, so EX/MEM captures the result.
  - Next state=RUN. ex_div_req in this cycle is ignored (no restart).
- DIV_WAIT, div_ready=0, wait counter < DIV_TIMEOUT-1: stall=001111, counter increments.
- DIV_WAIT, div_ready=0, counter == DIV_TIMEOUT-1: div_annul=1, stall=000000, div_timeout_err<=1, next state=RUN.
- div_ready arriving in the timeout cycle: div_ready wins and no error is raised.
- div_ready while in RUN: ignored.
- div_timeout_err is cleared only by reset.
- stall_cycles increments on every clock with stall[0]=1 and holds at all-ones (saturates). Flush cycles are not counted.
- Divider latency seen by the pipeline is 1 (start cycle) plus N DIV_WAIT cycles, where N is the cycle index at which div_ready arrives.

Decomposition:
- Shared defines header: stall vector codes STALL_NONE=000000, STALL_ID=000111, STALL_EX=001111; state encodings; RstEnable redefined as 1'b0 for this block's polarity; ZeroWord.
- One natural sub-module: sat_counter (parameterised width, inc enable, async active-low clear), used for stall_cycles.
- The wait counter stays inline.

Test Plan:
- Reset: assert rst=0 mid-DIV_WAIT with counter=10 -> immediately stall=000000, div_busy=0; after release the state is RUN and stall_cycles=0.
- Load-use: id_stallreq=1 for 2 cycles -> stall=000111 for exactly those 2 cycles; stall_cycles goes 0->2; no div_start.
- Divide: ex_div_req=1, div_ready pulsed 5 cycles after div_start -> div_start high for 1 cycle; stall=001111 for 6 cycles total, then 000000 in the ready cycle; stall_cycles=6; no second div_start.
- Timeout: DIV_TIMEOUT=8, div_ready never asserted -> div_annul pulses on the 8th DIV_WAIT cycle; div_timeout_err=1 and stays set; the state returns to RUN.
- Exception during divide: excp_valid=1 with excp_pc=0x00000020 on DIV_WAIT cycle 3 -> flush=1, new_pc=0x00000020, div_annul=1, stall=000000 in the same cycle; the next cycle is RUN with stall=000000.
- Simultaneous events: in RUN, excp_valid=1 with ex_div_req=1 and id_stallreq=1 -> flush=1, div_start=0, div_annul=1, stall=000000.
